// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/capture sequencer:
// opcodes, FSM state encoding and per-opcode helpers.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHR = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd3;
    localparam logic [3:0] OP_ROR = 4'd4;
    localparam logic [3:0] OP_ROL = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_NEG = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;

    // Hold counter width; MUL_CYCLES/DIV_CYCLES must fit.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_SHR) && (op <= OP_ROL);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_NOT;
    endfunction

    function automatic logic [CNT_W-1:0] op_hold(
        input logic [3:0] op,
        input int         mul_c,
        input int         div_c
    );
        if (op == OP_MUL) return CNT_W'(mul_c);
        if (op == OP_DIV) return CNT_W'(div_c);
        return CNT_W'(1);
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle issue/capture front end for the datapath ALU.
// Drives one-hot ctrl and operands, then captures ZHI/ZLO.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] ra_val,
    input  logic [WIDTH-1:0] rb_val,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [11:0]      alu_ctrl,
    input  logic [WIDTH-1:0] alu_zhi,
    input  logic [WIDTH-1:0] alu_zlo,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic             res_err
);

    state_t           state;
    state_t           state_nx;
    logic [3:0]       op_q;
    logic [CNT_W-1:0] cnt;
    logic             bad_op;
    logic             div0;
    logic             accept;
    logic             last;
    logic             wide_res;

    assign bad_op   = !is_legal(opcode);
    assign div0     = (opcode == OP_DIV) && (rb_val == '0);
    assign accept   = (state == IDLE) && op_valid;
    assign last     = (cnt == CNT_W'(1));
    assign wide_res = (op_q == OP_MUL) || (op_q == OP_DIV);

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    // Next state and handshake/control outputs.
    always_comb begin
        state_nx  = state;
        op_ready  = 1'b0;
        alu_ctrl  = '0;
        res_valid = 1'b0;
        unique case (state)
            IDLE: begin
                op_ready = clr;
                if (op_valid) begin
                    if (bad_op || div0) state_nx = DONE;
                    else                state_nx = EXEC;
                end
            end
            EXEC: begin
                alu_ctrl = 12'd1 << op_q;
                if (last) state_nx = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, hold counter and result capture.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q    <= '0;
            cnt     <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            res_lo  <= '0;
            res_hi  <= '0;
            res_err <= 1'b0;
        end else if (accept) begin
            op_q  <= opcode;
            alu_a <= ra_val;
            if (is_shift(opcode)) alu_b <= WIDTH'(rb_val[4:0]);
            else                  alu_b <= rb_val;
            cnt <= op_hold(opcode, MUL_CYCLES, DIV_CYCLES);
            if (bad_op) begin
                res_err <= 1'b1;
                res_lo  <= '0;
                res_hi  <= '0;
            end else if (div0) begin
                res_err <= 1'b1;
                res_lo  <= '0;
                res_hi  <= ra_val;
            end
        end else if (state == EXEC) begin
            cnt <= cnt - CNT_W'(1);
            if (last) begin
                res_lo  <= alu_zlo;
                res_hi  <= wide_res ? alu_zhi : '0;
                res_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural
// ALU stand-in and a spec-level reference of each operation.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  opcode;
    logic [31:0] ra_val;
    logic [31:0] rb_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [11:0] alu_ctrl;
    logic [31:0] alu_zhi;
    logic [31:0] alu_zlo;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_lo;
    logic [31:0] res_hi;
    logic        res_err;

    int n_vec = 0;
    int n_err = 0;

    alu_sequencer #(
        .WIDTH(32),
        .MUL_CYCLES(2),
        .DIV_CYCLES(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .opcode(opcode),
        .ra_val(ra_val),
        .rb_val(rb_val),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_ctrl(alu_ctrl),
        .alu_zhi(alu_zhi),
        .alu_zlo(alu_zlo),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_lo(res_lo),
        .res_hi(res_hi),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: decodes the one-hot control it is given.
    always_comb begin
        logic [63:0] w;
        w       = '0;
        alu_zhi = 32'hA5A5_5A5A;
        alu_zlo = 32'h0;
        case (alu_ctrl)
            12'h001: alu_zlo = alu_a + alu_b;
            12'h002: alu_zlo = alu_a - alu_b;
            12'h004: alu_zlo = alu_a >> alu_b;
            12'h008: alu_zlo = alu_a << alu_b;
            12'h010: alu_zlo = (alu_a >> alu_b[4:0])
                             | (alu_a << (6'd32 - {1'b0, alu_b[4:0]}));
            12'h020: alu_zlo = (alu_a << alu_b[4:0])
                             | (alu_a >> (6'd32 - {1'b0, alu_b[4:0]}));
            12'h040: alu_zlo = alu_a & alu_b;
            12'h080: alu_zlo = alu_a | alu_b;
            12'h100: begin
                w       = 64'(alu_a) * 64'(alu_b);
                alu_zlo = w[31:0];
                alu_zhi = w[63:32];
            end
            12'h200: begin
                if (alu_b != 0) begin
                    alu_zlo = alu_a / alu_b;
                    alu_zhi = alu_a % alu_b;
                end
            end
            12'h400: alu_zlo = 32'h0 - alu_a;
            12'h800: alu_zlo = ~alu_a;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Expected outcome of one request, from the operation table.
    function automatic void ref_op(
        input  logic [3:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] lo,
        output logic [31:0] hi,
        output logic [31:0] bx,
        output logic        err,
        output int          hold
    );
        int          s;
        logic [63:0] w;
        s    = int'(b % 32);
        bx   = (op >= 2 && op <= 5) ? 32'(s) : b;
        lo   = '0;
        hi   = '0;
        err  = 1'b0;
        hold = 1;
        case (op)
            4'd0:  lo = a + b;
            4'd1:  lo = a - b;
            4'd2:  lo = a >> s;
            4'd3:  lo = a << s;
            4'd4:  begin w = {a, a} >> s; lo = w[31:0];  end
            4'd5:  begin w = {a, a} << s; lo = w[63:32]; end
            4'd6:  lo = a & b;
            4'd7:  lo = a | b;
            4'd8:  begin
                w    = 64'(a) * 64'(b);
                lo   = w[31:0];
                hi   = w[63:32];
                hold = 2;
            end
            4'd9:  begin
                if (b == 0) begin
                    err  = 1'b1;
                    hi   = a;
                    hold = 0;
                end else begin
                    lo   = a / b;
                    hi   = a % b;
                    hold = 4;
                end
            end
            4'd10: lo = 32'h0 - a;
            4'd11: lo = ~a;
            default: begin
                err  = 1'b1;
                hold = 0;
            end
        endcase
    endfunction

    // One request: issue, watch execution, backpressure, handoff.
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int bp);
        logic [31:0] elo, ehi, ebx;
        logic        eerr;
        int          hold, lat, ctl;
        ref_op(op, a, b, elo, ehi, ebx, eerr, hold);
        @(negedge clk);
        chk("op_ready_idle", 64'(op_ready), 64'd1);
        op_valid = 1'b1;
        opcode   = op;
        ra_val   = a;
        rb_val   = b;
        @(negedge clk);
        op_valid = 1'b0;
        ra_val   = $urandom;
        rb_val   = $urandom;
        lat      = 1;
        ctl      = 0;
        while (!res_valid && lat < 30) begin
            if (alu_ctrl != 0) begin
                ctl++;
                chk("alu_ctrl", 64'(alu_ctrl), 64'(12'd1 << op));
                chk("alu_a", 64'(alu_a), 64'(a));
                chk("alu_b", 64'(alu_b), 64'(ebx));
            end
            chk("op_ready_busy", 64'(op_ready), 64'd0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(1 + hold));
        chk("ctrl_cycles", 64'(ctl), 64'(hold));
        chk("res_lo", 64'(res_lo), 64'(elo));
        chk("res_hi", 64'(res_hi), 64'(ehi));
        chk("res_err", 64'(res_err), 64'(eerr));
        chk("ctrl_done", 64'(alu_ctrl), 64'd0);
        for (int i = 0; i < bp; i++) begin
            op_valid = 1'b1;
            opcode   = 4'd0;
            @(negedge clk);
            chk("bp_valid", 64'(res_valid), 64'd1);
            chk("bp_ready", 64'(op_ready), 64'd0);
            chk("bp_lo", 64'(res_lo), 64'(elo));
            chk("bp_ctrl", 64'(alu_ctrl), 64'd0);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("handoff_valid", 64'(res_valid), 64'd0);
        chk("handoff_ready", 64'(op_ready), 64'd1);
        chk("kept_lo", 64'(res_lo), 64'(elo));
        chk("kept_err", 64'(res_err), 64'(eerr));
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        clr       = 1'b0;
        op_valid  = 1'b0;
        res_ready = 1'b0;
        opcode    = '0;
        ra_val    = '0;
        rb_val    = '0;
        #2;
        chk("rst_op_ready", 64'(op_ready), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_ctrl", 64'(alu_ctrl), 64'd0);
        chk("rst_lo_hi", {res_lo, res_hi}, 64'd0);
        chk("rst_ab", {alu_a, alu_b}, 64'd0);
        chk("rst_err", 64'(res_err), 64'd0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;

        issue(4'd0, 32'd5, 32'd7, 0);
        issue(4'd8, 32'h0001_0000, 32'h0001_0000, 0);
        issue(4'd9, 32'd100, 32'd0, 0);
        issue(4'd5, 32'h8000_0001, 32'd33, 0);
        issue(4'd13, 32'hDEAD_BEEF, 32'h1234, 0);
        issue(4'd1, 32'd10, 32'd20, 5);
        issue(4'd9, 32'd1000, 32'd7, 1);
        issue(4'd4, 32'h0000_00F1, 32'd0, 0);
        issue(4'd2, 32'hF000_0000, 32'hFFFF_FFFF, 0);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            issue(op, a, b, int'($urandom_range(0, 3)));
        end

        // Reset during the second EXEC cycle of a divide.
        issue(4'd11, 32'h0F0F_0000, 32'd0, 0);
        @(negedge clk);
        op_valid = 1'b1;
        opcode   = 4'd9;
        ra_val   = 32'd1000;
        rb_val   = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        chk("abort_ctrl1", 64'(alu_ctrl), 64'h200);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("abort_ctrl", 64'(alu_ctrl), 64'd0);
        chk("abort_ab", {alu_a, alu_b}, 64'd0);
        chk("abort_res", {res_lo, res_hi}, 64'd0);
        chk("abort_err", 64'(res_err), 64'd0);
        chk("abort_valid", 64'(res_valid), 64'd0);
        chk("abort_ready", 64'(op_ready), 64'd0);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("post_ready", 64'(op_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_valid", 64'(res_valid), 64'd0);
            chk("post_ctrl", 64'(alu_ctrl), 64'd0);
        end
        issue(4'd7, 32'h1200_0034, 32'h0056_0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle issue/capture front end for the datapath ALU. This is the side that drives the ALU's one-hot 12-bit control, operands and result capture.
- Accepts an encoded operation plus two register operands over a valid/ready handshake.
- Drives one-hot ctrl and operands for the required number of cycles, then captures ZHI/ZLO into result registers.
- Presents the result over a second valid/ready handshake. Sits between the control unit / register file and the ALU.

Parameters:
- WIDTH, 32: operand/result width.
- MUL_CYCLES, 2: cycles ctrl is held for multiply before capture (>=1).
- DIV_CYCLES, 4: cycles ctrl is held for divide before capture (>=1).

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- op_valid  in  1  operation request valid
- op_ready  out  1  sequencer can accept a request
- opcode  in  4  operation code (table below)
- ra_val  in  WIDTH  operand A
- rb_val  in  WIDTH  operand B
- alu_a  out  WIDTH  ALU operand A
- alu_b  out  WIDTH  ALU operand B
- alu_ctrl  out  12  one-hot ALU control
- alu_zhi  in  WIDTH  ALU high result
- alu_zlo  in  WIDTH  ALU low result
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_lo  out  WIDTH  captured low result
- res_hi  out  WIDTH  captured high result
- res_err  out  1  illegal opcode or divide-by-zero

Behaviour:
- Opcode table, where alu_ctrl bit = opcode:
  - 0 add, 1 sub, 2 shr, 3 shl, 4 ror, 5 rol
  - 6 and, 7 or, 8 mul, 9 div, 10 neg, 11 not
  - 12-15 illegal
- Reset (clr=0, async): state IDLE. op_ready=0 while clr=0. All other outputs 0: alu_ctrl, alu_a, alu_b, res_valid, res_lo, res_hi, res_err, cycle counter.
- States: IDLE, EXEC, DONE.
- IDLE:
  - op_ready=1, alu_ctrl=0.
  - On op_valid&&op_ready: register opcode, alu_a=ra_val, alu_b=rb_val.
  - For opcodes 2-5, alu_b = {0, rb_val[4:0]}, i.e. shift/rotate amount is taken mod 32.
  - Load counter with hold count: 1 for simple ops, MUL_CYCLES for mul, DIV_CYCLES for div. Go to EXEC.
  - Illegal opcode, or div with rb_val==0: skip EXEC and go directly to DONE with res_err=1.
    - Illegal: res_lo=res_hi=0.
    - Div-by-zero: res_lo=0, res_hi=ra_val.
- EXEC:
  - alu_ctrl = 1<<opcode, held stable along with alu_a/alu_b; op_ready=0.
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, capture on the clock edge:
    - res_lo = alu_zlo.
    - res_hi = alu_zhi for mul/div, else 0.
  - res_err=0; go to DONE.
- DONE:
  - res_valid=1, alu_ctrl=0, op_ready=0. res_* held stable until res_ready=1.
  - On res_valid&&res_ready: res_valid=0 next cycle, go to IDLE.
  - res_lo/res_hi/res_err keep their last values after handoff.
- Latency, accept edge to res_valid high: 1 cycle + hold count. Simple op: res_valid high 2 edges after accept. Error cases: 1 edge.
- Throughput: one op in flight. New op accepted only in IDLE, so earliest re-accept is the cycle after result handoff.
- alu_ctrl is always zero or exactly one-hot. Never two bits set; never a bit 12+.
- op_valid while not IDLE: ignored (op_ready=0). Requester holds the request.
- res_ready asserted before res_valid: no effect.
- clr asserted mid-EXEC or mid-DONE: in-flight op discarded. No result is delivered, and after reset release the block sits in IDLE.
- Arithmetic is unsigned, as computed by the ALU. The sequencer does no arithmetic except the operand mask and the counter.

Decomposition:
- Shared package alu_pkg holds:
  - Opcode localparams (OP_ADD=0 ... OP_NOT=11).
  - State encoding IDLE/EXEC/DONE.
  - Function op_hold(opcode) returning the hold count.
  - Function is_shift(opcode).
- No sub-module needed. An optional alu_hold_counter (load/decrement/at-one flag) may be split out if reused by the memory sequencer.

Test Plan:
- add: opcode=0, ra=5, rb=7; ALU model returns zlo=12 -> alu_ctrl=12'h001 for 1 cycle; res_lo=12, res_hi=0, res_err=0; res_valid 2 edges after accept.
- mul: opcode=8, MUL_CYCLES=2, ra=32'h0001_0000, rb=32'h0001_0000 -> alu_ctrl=12'h100 for exactly 2 cycles; res_hi=1, res_lo=0.
- div-by-zero: opcode=9, ra=100, rb=0 -> alu_ctrl stays 0; res_valid 1 edge after accept; res_err=1, res_lo=0, res_hi=100.
- Shift mask and illegal opcode:
  - rol opcode=5, rb=33 -> alu_b=1.
  - Opcode 13 -> res_err=1, res_lo=res_hi=0, alu_ctrl never nonzero.
- Backpressure: res_ready low 5 cycles after res_valid -> res_lo stable, op_ready=0, second op_valid ignored. res_ready high -> IDLE, second op accepted next cycle.
- Reset mid-op: div with DIV_CYCLES=4, clr low during 2nd EXEC cycle -> all outputs 0 immediately (async). After release, op_ready=1 and res_valid never asserted for the aborted op.
